load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- Sits between the core's execute stage and data_memory.
- Turns one RISC-V load/store request (LB/LH/LW/LBU/LHU/SB/SH/SW) into a sequence of single-byte memory accesses, because data memory only moves one byte per access.
- Assembles little-endian load results with sign/zero extension.
- Flags misaligned, out-of-range or illegal-funct3 requests without touching memory.

Parameters:
- MEM_BYTES, 128, size of the byte-addressed data memory; addresses >= MEM_BYTES are errors.
- ADDR_W, 32, width of the core and memory address buses.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  core presents a request; accepted only while req_ready=1.
- req_ready  out  1  unit idle and able to accept a request.
- req_store  in  1  1=store, 0=load.
- req_funct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU legal for loads only).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data; low 8/16/32 bits used.
- resp_done  out  1  one-cycle pulse: request completed successfully.
- resp_err  out  1  one-cycle pulse: request rejected; no memory access made.
- resp_rdata  out  32  extended load result; valid while resp_done=1, otherwise 0.
- mem_read  out  1  byte read strobe to data memory.
- mem_write  out  1  byte write strobe to data memory.
- endereco  out  ADDR_W  byte address to data memory.
- write_data  out  32  store byte in [7:0]; upper bits 0.
- read_data  in  32  data memory output, combinational; only [7:0] used.

Behaviour:
- Reset: state IDLE, counter 0, captured request cleared. Outputs: req_ready=1, resp_done=0, resp_err=0, resp_rdata=0, mem_read=0, mem_write=0, endereco=0, write_data=0. Reset has priority over every other event.
- FSM states:
  - IDLE: req_ready=1. On req_valid, latch store/funct3/addr/wdata.
    - Illegal request: go to ERR.
    - Otherwise: N = 1/2/4 for B/H/W, counter = 0, go to ACCESS.
  - Illegal request means any of:
    - funct3 not listed above;
    - store with funct3 100/101;
    - H with addr[0]=1;
    - W with addr[1:0]!=0;
    - addr+N-1 >= MEM_BYTES.
  - ACCESS: one byte per cycle. endereco = base+counter.
    - Load: mem_read=1; capture read_data[7:0] into byte lane counter at the clock edge.
    - Store: mem_write=1; write_data = {24'b0, wdata byte lane counter}.
    - Counter increments each cycle. After lane N-1, go to DONE.
  - DONE: resp_done=1 for one cycle, then IDLE.
    - Load: resp_rdata = assembled value. B/H are sign-extended from bit 7/15; BU/HU are zero-extended.
    - Store: resp_rdata=0.
  - ERR: resp_err=1 for one cycle, mem strobes 0, then IDLE.
- Strobe exclusivity: mem_read and mem_write are never both 1. Both are 0 outside ACCESS, and endereco/write_data are 0 outside ACCESS.
- Latency: accept edge, then N ACCESS cycles, then the DONE cycle. resp_done asserts N+1 cycles after acceptance. Error responses assert 1 cycle after acceptance.
- Request stability: req_ready=0 in ACCESS, DONE and ERR. req_valid is ignored in those states, and req_* inputs may change freely after acceptance.
- Back-to-back requests: a new request is accepted on the first IDLE cycle after DONE/ERR.
- Reset mid-ACCESS: returns to IDLE next edge with no resp pulse. Bytes already stored stay written; no rollback.
- Little-endian byte order: lane k lives at address base+k.

Decomposition:
- Shared package lsu_pkg holds:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - FSM state encoding (IDLE, ACCESS, DONE, ERR);
  - size-decode constants.
- One natural sub-module, lsu_extend: combinational byte/half/word sign/zero extension of the assembled 32-bit value by funct3.

Test Plan:
- SW addr=0x10 wdata=0xDEADBEEF, then LW 0x10 -> mem[0x10..0x13]=EF,BE,AD,DE over 4 write cycles; LW resp_rdata=0xDEADBEEF, resp_done 5 cycles after acceptance.
- SB addr=0x21 wdata=0x00000080, then LB 0x21 and LBU 0x21 -> LB resp_rdata=0xFFFFFF80; LBU resp_rdata=0x00000080; only one mem_write cycle for SB.
- SH addr=0x30 wdata=0x12348001, then LH 0x30 and LHU 0x30 -> mem[0x30]=01, mem[0x31]=80; LH=0xFFFF8001; LHU=0x00008001.
- Error requests: LW addr=0x11, SH addr=0x05, LW addr=0x7E (MEM_BYTES=128), store with funct3=100 -> each gives resp_err pulse 1 cycle after acceptance, mem_read=mem_write=0 throughout, memory unchanged.
- rst_n=0 on the 2nd ACCESS cycle of SW addr=0x40 wdata=0xAABBCCDD -> no resp pulse; all outputs at reset values next cycle; mem[0x40]=DD, mem[0x41] unchanged (00); req_ready=1 after reset.
- Back-to-back: hold req_valid=1 with a second request during ACCESS of the first -> second accepted only on the IDLE cycle after the first resp_done; no overlapping strobes.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the byte-serial load/store unit: funct3 codes,
// FSM state encoding and access-size decode.
package lsu_pkg;

    // RISC-V load/store funct3 encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Access sizes in bytes
    localparam logic [2:0] SIZE_B = 3'd1;
    localparam logic [2:0] SIZE_H = 3'd2;
    localparam logic [2:0] SIZE_W = 3'd4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2,
        ERR    = 2'd3
    } lsu_state_e;

    // Number of bytes moved for a funct3; unlisted codes report word size
    // so the range check stays conservative (they are rejected anyway).
    function automatic logic [2:0] f3_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return SIZE_B;
            F3_H, F3_HU: return SIZE_H;
            default:     return SIZE_W;
        endcase
    endfunction

    // funct3 legality by direction; unsigned variants exist only for loads
    function automatic logic f3_legal(input logic store, input logic [2:0] f3);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return !store;
            default:          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_extend.sv
// Sign/zero extension of an assembled little-endian load value by funct3.
module lsu_extend
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] raw,
    output logic [31:0] ext
);

    // Select extension width and kind from funct3
    always_comb begin
        ext = raw;
        case (funct3)
            F3_B:    ext = {{24{raw[7]}}, raw[7:0]};
            F3_H:    ext = {{16{raw[15]}}, raw[15:0]};
            F3_BU:   ext = {24'b0, raw[7:0]};
            F3_HU:   ext = {16'b0, raw[15:0]};
            default: ext = raw;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: serialises one B/H/W request into single-byte data
// memory accesses, assembles little-endian loads and rejects illegal
// requests without touching memory.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 128,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_done,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] endereco,
    output logic [31:0]       write_data,
    input  logic [31:0]       read_data
);

    localparam int unsigned AW1 = ADDR_W + 1;

    lsu_state_e        state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              store_q, store_d;
    logic [2:0]        f3_q, f3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rbuf_q, rbuf_d;

    logic [2:0]        req_size;
    logic [AW1-1:0]    req_last;
    logic              req_illegal;
    logic [1:0]        last_lane;
    logic [31:0]       ext_rdata;

    // Memory returns a full word but only the addressed byte is meaningful
    logic unused_rd_hi;
    assign unused_rd_hi = ^read_data[31:8];

    // Classify the incoming request: funct3, alignment and address range
    always_comb begin
        req_size    = f3_size(req_funct3);
        req_last    = {1'b0, req_addr} + AW1'(req_size) - AW1'(1);
        req_illegal = !f3_legal(req_store, req_funct3);
        if (req_size == SIZE_H && req_addr[0]) begin
            req_illegal = 1'b1;
        end
        if (req_size == SIZE_W && req_addr[1:0] != 2'b00) begin
            req_illegal = 1'b1;
        end
        if (req_last >= AW1'(MEM_BYTES)) begin
            req_illegal = 1'b1;
        end
    end

    assign last_lane = 2'(f3_size(f3_q) - 3'd1);

    lsu_extend u_extend (
        .funct3 (f3_q),
        .raw    (rbuf_q),
        .ext    (ext_rdata)
    );

    // Next-state, request capture, byte sequencing and output decode
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        store_d    = store_q;
        f3_d       = f3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rbuf_d     = rbuf_q;

        req_ready  = 1'b0;
        resp_done  = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        endereco   = '0;
        write_data = '0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    store_d = req_store;
                    f3_d    = req_funct3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = '0;
                    rbuf_d  = '0;
                    state_d = req_illegal ? ERR : ACCESS;
                end
            end

            ACCESS: begin
                endereco = addr_q + ADDR_W'(cnt_q);
                // Strobes are held off while rst_n is low so the edge that
                // resets the FSM cannot also commit the in-flight byte.
                if (store_q) begin
                    mem_write  = rst_n;
                    write_data = {24'b0, wdata_q[{cnt_q, 3'b000} +: 8]};
                end else begin
                    mem_read = rst_n;
                    rbuf_d[{cnt_q, 3'b000} +: 8] = read_data[7:0];
                end
                if (cnt_q == last_lane) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end

            DONE: begin
                resp_done  = 1'b1;
                resp_rdata = store_q ? '0 : ext_rdata;
                state_d    = IDLE;
            end

            ERR: begin
                resp_err = 1'b1;
                state_d  = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and captured-request registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            store_q <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rbuf_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            store_q <= store_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rbuf_q  <= rbuf_d;
        end
    end

endmodule
